// File: rtl/adc_frame_tagger.sv
`default_nettype none
// ============================================================================
//  adc_frame_tagger
//  Inserts trigger-numbered header words into the ADC sample stream.
//  Optional FRAME_TRAILER_EN adds a word-count trailer in front of headers.
//  Rev 1.0
// ============================================================================
module adc_frame_tagger #(
    parameter logic [3:0] HEADER_ID   = 4'hE,
    parameter logic [3:0] TRAILER_ID  = 4'hD,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,
    input  logic        ENABLE,
    input  logic        TRIG,
    input  logic        IN_VALID,
    input  logic [31:0] IN_DATA,
    output logic        IN_READY,
    output logic        OUT_EMPTY,
    output logic [31:0] OUT_DATA,
    input  logic        OUT_READ,
    output logic [27:0] TRIG_CNT,
    output logic        TRIG_LOST
);

`ifdef FRAME_TRAILER_EN
    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_HDR  = 2'd1,
        ST_TRL  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_HDR  = 2'd1
    } state_t;
`endif

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pending;
    logic                   r_trig_lost;
    logic [27:0]            r_trig_cnt;
    logic [27:0]            r_hdr_num;
    logic                   r_out_empty;
    logic [31:0]            r_out_data;

    logic                   w_edge;
    logic                   w_edge_en;
    logic                   w_slot_free;
    logic                   w_inject;
    logic                   w_block;
    logic                   w_hdr_load;
    logic                   w_data_load;
    logic                   w_pend_after;
    logic [27:0]            w_cnt_inc;

`ifdef FRAME_TRAILER_EN
    logic                   r_enable_d;
    logic                   r_trl_req;
    logic                   r_hdr_open;
    logic [27:0]            r_word_cnt;
    logic                   w_trl_load;
    logic                   w_en_fall;
`else
    logic                   w_unused_trailer_id;
    assign w_unused_trailer_id = ^TRAILER_ID;
`endif

    // Newest sample enters at bit 0; the edge is seen on the two oldest stages.
    assign w_edge       = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    assign w_edge_en    = w_edge & ENABLE;
    assign w_slot_free  = r_out_empty | OUT_READ;
    assign w_inject     = r_pending & ENABLE;
    assign w_cnt_inc    = r_trig_cnt + 28'd1;
    assign w_pend_after = r_pending & ~w_hdr_load;

    assign IN_READY  = BUS_RST_N & w_slot_free & ~w_block;
    assign OUT_EMPTY = r_out_empty;
    assign OUT_DATA  = r_out_data;
    assign TRIG_CNT  = r_trig_cnt;
    assign TRIG_LOST = r_trig_lost;

`ifdef FRAME_TRAILER_EN
    assign w_en_fall = r_enable_d & ~ENABLE;
`endif

    always_comb begin
        w_hdr_load  = 1'b0;
        w_block     = w_inject;
`ifdef FRAME_TRAILER_EN
        w_trl_load  = 1'b0;
        w_state_nxt = (r_state == ST_TRL) ? ST_TRL : ST_PASS;
        if (r_state == ST_TRL) begin
            // The header owed after a trailer goes out even if ENABLE dropped.
            w_block    = 1'b1;
            w_hdr_load = w_slot_free;
            if (w_slot_free) begin
                w_state_nxt = ST_HDR;
            end
        end else begin
            w_block = w_inject | r_trl_req;
            if (w_slot_free && r_trl_req) begin
                w_trl_load = 1'b1;
            end else if (w_slot_free && w_inject && r_hdr_open) begin
                w_trl_load  = 1'b1;
                w_state_nxt = ST_TRL;
            end else if (w_slot_free && w_inject) begin
                w_hdr_load  = 1'b1;
                w_state_nxt = ST_HDR;
            end
        end
`else
        w_state_nxt = (r_state == ST_HDR) ? ST_PASS : r_state;
        if (w_slot_free && w_inject) begin
            w_hdr_load  = 1'b1;
            w_state_nxt = ST_HDR;
        end
`endif
        w_data_load = w_slot_free & ~w_block & IN_VALID;
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_state <= ST_PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_sync      <= '0;
            r_pending   <= 1'b0;
            r_trig_lost <= 1'b0;
            r_trig_cnt  <= '0;
            r_hdr_num   <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], TRIG};
            r_trig_cnt <= w_edge_en ? w_cnt_inc : r_trig_cnt;
            // A header load frees the slot before a same-cycle edge claims it.
            r_pending  <= w_pend_after | w_edge_en;
            if (w_edge_en && !w_pend_after) begin
                r_hdr_num <= w_cnt_inc;
            end
            if (!ENABLE) begin
                r_trig_lost <= 1'b0;
            end else if (w_edge_en && w_pend_after) begin
                r_trig_lost <= 1'b1;
            end
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_out_empty <= 1'b1;
            r_out_data  <= '0;
        end else if (w_hdr_load) begin
            r_out_empty <= 1'b0;
            r_out_data  <= {HEADER_ID, r_hdr_num};
`ifdef FRAME_TRAILER_EN
        end else if (w_trl_load) begin
            r_out_empty <= 1'b0;
            r_out_data  <= {TRAILER_ID, r_word_cnt};
`endif
        end else if (w_data_load) begin
            r_out_empty <= 1'b0;
            r_out_data  <= IN_DATA;
        end else if (OUT_READ) begin
            r_out_empty <= 1'b1;
        end
    end

`ifdef FRAME_TRAILER_EN
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            r_enable_d <= 1'b0;
            r_trl_req  <= 1'b0;
            r_hdr_open <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_enable_d <= ENABLE;
            r_trl_req  <= w_trl_load ? 1'b0 : (r_trl_req | (w_en_fall & r_hdr_open));
            if (w_hdr_load) begin
                r_hdr_open <= 1'b1;
            end else if (w_trl_load) begin
                r_hdr_open <= 1'b0;
            end
            if (w_hdr_load) begin
                r_word_cnt <= '0;
            end else if (w_data_load && (r_word_cnt != 28'hFFFFFFF)) begin
                r_word_cnt <= r_word_cnt + 28'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_tagger.sv
`default_nettype none
// ============================================================================
//  tb_adc_frame_tagger
//  Randomised and directed stimulus, checked against a stream-level model.
//  Rev 1.0
// ============================================================================
module tb_adc_frame_tagger;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        TRIG = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [31:0] IN_DATA = '0;
    logic        IN_READY;
    logic        OUT_EMPTY;
    logic [31:0] OUT_DATA;
    logic        OUT_READ = 1'b0;
    logic [27:0] TRIG_CNT;
    logic        TRIG_LOST;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] q_in[$];
    logic [31:0] q_out[$];
    int          tb_rdy_low = 0;
    int          tb_hdr_num = 0;
    bit          tb_hdr_open = 0;
    int          tb_data_cnt = 0;

    adc_frame_tagger dut (
        .BUS_CLK   (BUS_CLK),
        .BUS_RST_N (BUS_RST_N),
        .ENABLE    (ENABLE),
        .TRIG      (TRIG),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .IN_READY  (IN_READY),
        .OUT_EMPTY (OUT_EMPTY),
        .OUT_DATA  (OUT_DATA),
        .OUT_READ  (OUT_READ),
        .TRIG_CNT  (TRIG_CNT),
        .TRIG_LOST (TRIG_LOST)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Record both handshakes mid-cycle, where inputs and outputs are stable.
    always @(negedge BUS_CLK) begin
        if (BUS_RST_N && IN_VALID && IN_READY) q_in.push_back(IN_DATA);
        if (BUS_RST_N && !OUT_EMPTY && OUT_READ) q_out.push_back(OUT_DATA);
        if (BUS_RST_N && IN_VALID && !IN_READY) tb_rdy_low++;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        BUS_RST_N = 1'b0;
        ENABLE    = 1'b0;
        TRIG      = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READ  = 1'b0;
        repeat (3) @(posedge BUS_CLK);
        #1;
        BUS_RST_N = 1'b1;
        q_in.delete();
        q_out.delete();
        tb_hdr_num  = 0;
        tb_hdr_open = 0;
        tb_data_cnt = 0;
    endtask

    task automatic trig_pulse();
        @(posedge BUS_CLK); #1 TRIG = 1'b1;
        @(posedge BUS_CLK); #1 TRIG = 1'b0;
    endtask

    task automatic drain(input int cycles);
        @(posedge BUS_CLK); #1;
        IN_VALID = 1'b0;
        OUT_READ = 1'b1;
        TRIG     = 1'b0;
        repeat (cycles) @(posedge BUS_CLK);
        #1;
    endtask

    // Random valid/ready traffic; data kept below 0x80000000 so tagged words stand out.
    task automatic run_traffic(input int cycles, input int valid_pct, input int read_pct,
                               input int trig_period, input int trig_offset, output int ntrig);
        bit x;
        ntrig = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge BUS_CLK);
            x = IN_VALID && IN_READY;
            @(posedge BUS_CLK); #1;
            if (x || !IN_VALID) begin
                IN_VALID = ($urandom_range(99) < valid_pct);
                IN_DATA  = $urandom() & 32'h7FFF_FFFF;
            end
            OUT_READ = ($urandom_range(99) < read_pct);
            TRIG     = ((c % trig_period) == trig_offset);
            if (TRIG) ntrig++;
        end
    endtask

    // Walks the observed output stream: data must replay the accepted input in
    // order, headers count up from the last seen number, trailers carry the
    // number of data words since the previous header.
    task automatic check_stream(input string tag, input int exp_hdrs);
        int          hdrs = 0;
        bit          prev_trl = 0;
        logic [31:0] w;
        foreach (q_out[k]) begin
            w = q_out[k];
            if (!w[31]) begin
                if (q_in.size() == 0) check_value({tag, "_extra_data"}, w, 32'hFFFF_FFFF);
                else check_value({tag, "_data"}, w, q_in.pop_front());
                tb_data_cnt++;
                prev_trl = 0;
            end else if (w[31:28] == 4'hE) begin
`ifdef FRAME_TRAILER_EN
                if (tb_hdr_open) check_value({tag, "_trl_before_hdr"}, {31'd0, prev_trl}, 32'd1);
`endif
                tb_hdr_num++;
                check_value({tag, "_hdr"}, w, {4'hE, tb_hdr_num[27:0]});
                hdrs++;
                tb_hdr_open = 1;
                tb_data_cnt = 0;
                prev_trl    = 0;
            end else begin
`ifdef FRAME_TRAILER_EN
                check_value({tag, "_trl"}, w, {4'hD, tb_data_cnt[27:0]});
                tb_hdr_open = 0;
                prev_trl    = 1;
`else
                check_value({tag, "_unexpected_word"}, w, 32'd0);
`endif
            end
        end
        check_value({tag, "_leftover_in"}, q_in.size(), 32'd0);
        check_value({tag, "_hdr_count"}, hdrs, exp_hdrs);
        q_out.delete();
    endtask

    initial begin
        int ntrig;

        // Reset state, including IN_READY held low while reset is asserted.
        OUT_READ = 1'b1;
        IN_VALID = 1'b1;
        repeat (2) @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        check_value("rst_in_ready", IN_READY, 0);
        check_value("rst_out_empty", OUT_EMPTY, 1);
        check_value("rst_out_data", OUT_DATA, 0);
        check_value("rst_trig_cnt", TRIG_CNT, 0);
        check_value("rst_trig_lost", TRIG_LOST, 0);

        // Pass-through with tagging disabled; triggers must be ignored.
        do_reset();
        OUT_READ = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge BUS_CLK); #1;
            IN_VALID = 1'b1;
            IN_DATA  = i;
            TRIG     = i[2];
            @(negedge BUS_CLK);
            check_value("pass_in_ready", IN_READY, 1);
            if (i > 0) begin
                check_value("pass_latency_data", OUT_DATA, i - 1);
                check_value("pass_latency_empty", OUT_EMPTY, 0);
            end
        end
        @(posedge BUS_CLK); #1;
        IN_VALID = 1'b0;
        TRIG     = 1'b0;
        @(negedge BUS_CLK);
        check_value("pass_last_word", OUT_DATA, 99);
        drain(6);
        check_value("pass_trig_cnt", TRIG_CNT, 0);
        check_stream("pass", 0);

        // Continuous data with one trigger: one header, one stall cycle.
        do_reset();
        ENABLE = 1'b1;
        tb_rdy_low = 0;
        run_traffic(30, 100, 100, 1000, 5, ntrig);
        drain(10);
        check_value("one_trig_rdy_low", tb_rdy_low, 1);
        check_value("one_trig_cnt", TRIG_CNT, 1);
        check_stream("one_trig", ntrig);

        // Random traffic with periodic triggers, continuing the header sequence.
        run_traffic(600, 60, 70, 37, 10, ntrig);
        drain(20);
        check_value("rand_trig_cnt", TRIG_CNT, 1 + ntrig);
        check_value("rand_trig_lost", TRIG_LOST, 0);
        check_stream("rand", ntrig);

        // Two edges while the output is blocked: second is lost but counted.
        do_reset();
        ENABLE = 1'b1;
        @(posedge BUS_CLK); #1;
        IN_VALID = 1'b1;
        IN_DATA  = 32'h0000_1234;
        @(posedge BUS_CLK); #1;
        IN_VALID = 1'b0;
        TRIG = 1'b1;
        @(posedge BUS_CLK); #1 TRIG = 1'b0;
        @(posedge BUS_CLK); #1 TRIG = 1'b1;
        @(posedge BUS_CLK); #1 TRIG = 1'b0;
        repeat (4) @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        check_value("lost_trig_cnt", TRIG_CNT, 2);
        check_value("lost_flag", TRIG_LOST, 1);
        check_value("lost_held_word", OUT_DATA, 32'h0000_1234);
        check_value("lost_in_ready", IN_READY, 0);
        drain(6);
        check_stream("lost", 1);
        ENABLE = 1'b0;
        @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        check_value("lost_cleared", TRIG_LOST, 0);

        // Count wrap: preload the counter to its maximum, then one more edge.
        do_reset();
        ENABLE   = 1'b1;
        OUT_READ = 1'b1;
        @(negedge BUS_CLK);
        force dut.r_trig_cnt = 28'hFFF_FFFF;
        @(posedge BUS_CLK); #1;
        release dut.r_trig_cnt;
        tb_hdr_num = 32'h0FFF_FFFF;
        trig_pulse();
        drain(8);
        check_value("wrap_trig_cnt", TRIG_CNT, 0);
        check_stream("wrap", 1);

        // Asynchronous reset with a word held and a header pending.
        do_reset();
        ENABLE = 1'b1;
        @(posedge BUS_CLK); #1;
        IN_VALID = 1'b1;
        IN_DATA  = 32'h0000_5555;
        @(posedge BUS_CLK); #1;
        IN_VALID = 1'b0;
        trig_pulse();
        repeat (4) @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        check_value("arst_pre_full", OUT_EMPTY, 0);
        check_value("arst_pre_cnt", TRIG_CNT, 1);
        #2 BUS_RST_N = 1'b0;
        #1;
        check_value("arst_empty", OUT_EMPTY, 1);
        check_value("arst_cnt", TRIG_CNT, 0);
        check_value("arst_in_ready", IN_READY, 0);
        @(posedge BUS_CLK); #1;
        BUS_RST_N = 1'b1;
        q_in.delete();
        q_out.delete();
        drain(10);
        check_value("arst_no_stale", q_out.size(), 0);
        check_value("arst_still_empty", OUT_EMPTY, 1);

`ifdef FRAME_TRAILER_EN
        // Trigger, five words, trigger: header, data, trailer, header.
        do_reset();
        ENABLE   = 1'b1;
        OUT_READ = 1'b1;
        trig_pulse();
        repeat (5) @(posedge BUS_CLK);
        for (int k = 0; k < 5; k++) begin
            @(posedge BUS_CLK); #1;
            IN_VALID = 1'b1;
            IN_DATA  = 32'h100 + k;
        end
        @(posedge BUS_CLK); #1;
        IN_VALID = 1'b0;
        trig_pulse();
        drain(10);
        check_value("trl_stream_len", q_out.size(), 8);
        if (q_out.size() == 8) begin
            check_value("trl_first_hdr", q_out[0], 32'hE000_0001);
            check_value("trl_word", q_out[6], 32'hD000_0005);
            check_value("trl_second_hdr", q_out[7], 32'hE000_0002);
        end
        check_stream("trl", 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
